// File: rtl/mips_cpu_pkg.sv
// Shared types for the CPU memory-side arbiter: FSM states, grant encoding,
// reset grant history and the word-alignment helper.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Seeding history with fetch makes the first tie after reset go to data.
  localparam grant_t     LAST_GRANT_RST = GRANT_I;
  localparam logic [3:0] BE_FULL        = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_timeout.sv
// Waitrequest watchdog for the memory arbiter; only present when
// MIPS_MEM_ARBITER_TIMEOUT_EN is defined.
`ifdef MIPS_MEM_ARBITER_TIMEOUT_EN
module mips_cpu_mem_timeout
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign o_expired = i_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates fetch and data-port requests onto one Avalon-style master.
// Optional waitrequest abort is enabled by MIPS_MEM_ARBITER_TIMEOUT_EN.
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  state_t      r_state, w_state_nxt;
  grant_t      r_grant, r_last_grant, w_grant_sel;
  logic        r_abort, r_read, r_write;
  logic [3:0]  r_byteenable;
  logic [31:0] r_address, r_writedata, r_i_rdata, r_d_rdata;
  logic        w_d_req, w_any_req, w_bus_done, w_abort;
  logic [31:0] w_rdata_in;

  assign w_d_req   = d_read | d_write;
  assign w_any_req = i_req | w_d_req;

  always_comb begin
    w_grant_sel = GRANT_I;
    if (i_req && w_d_req) begin
      w_grant_sel = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (w_d_req) begin
      w_grant_sel = GRANT_D;
    end
  end

`ifdef MIPS_MEM_ARBITER_TIMEOUT_EN
  logic w_expired;

  mips_cpu_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state != ISSUE),
    .i_en     ((r_state == ISSUE) && waitrequest),
    .o_expired(w_expired)
  );

  assign w_abort = w_expired;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_abort      = 1'b0;
`endif

  assign w_bus_done = (r_state == ISSUE) && (!waitrequest || w_abort);
  assign w_rdata_in = w_abort ? 32'h0 : readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ISSUE;
      ISSUE:   if (w_bus_done) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= LAST_GRANT_RST;
      r_last_grant <= LAST_GRANT_RST;
      r_abort      <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_byteenable <= '0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        r_grant      <= w_grant_sel;
        r_last_grant <= w_grant_sel;
        r_abort      <= 1'b0;
        if (w_grant_sel == GRANT_D) begin
          // A write wins when the data port raises both strobes.
          r_address    <= word_align(d_addr);
          r_write      <= d_write;
          r_read       <= !d_write;
          r_byteenable <= d_write ? d_byteenable : BE_FULL;
          r_writedata  <= d_write ? d_wdata : 32'h0;
        end else begin
          r_address    <= word_align(i_addr);
          r_write      <= 1'b0;
          r_read       <= 1'b1;
          r_byteenable <= BE_FULL;
          r_writedata  <= 32'h0;
        end
      end
      if (w_bus_done) begin
        if (r_read && (r_grant == GRANT_I)) r_i_rdata <= w_rdata_in;
        if (r_read && (r_grant == GRANT_D)) r_d_rdata <= w_rdata_in;
        r_read       <= 1'b0;
        r_write      <= 1'b0;
        r_byteenable <= '0;
        r_abort      <= w_abort;
      end
    end
  end

  assign i_ready    = (r_state == RESP) && (r_grant == GRANT_I);
  assign d_ready    = (r_state == RESP) && (r_grant == GRANT_D);
  assign err        = (r_state == RESP) && r_abort;
  assign stall      = w_any_req & ~(i_ready | d_ready);
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_byteenable;
  assign writedata  = r_writedata;

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Memory-side access controller directly downstream of the CPU load/store stage. Accepts word-aligned read/write requests from the data port (address, pre-merged write data, byte enables) and from the instruction-fetch port. Arbitrates between them and drives a single Avalon-style memory master with `waitrequest`. Returns read data with a one-cycle `ready` pulse and drives `stall` to the pipeline while any request is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 1024: waitrequest cycles tolerated before abort (used only with the timeout feature)
- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `i_req` in 1: fetch request, level, held until `i_ready`
- `i_addr` in 32: fetch address
- `i_rdata` out 32: fetched word
- `i_ready` out 1: one-cycle completion pulse, fetch
- `d_read` in 1: data read request, level
- `d_write` in 1: data write request, level; wins if both asserted
- `d_addr` in 32: data address
- `d_wdata` in 32: write data, already lane-aligned
- `d_byteenable` in 4: write lane enables
- `d_rdata` out 32: loaded word, raw, for lane extraction upstream
- `d_ready` out 1: one-cycle completion pulse, data
- `stall` out 1: high whenever any request is asserted and its ready has not yet pulsed
- `err` out 1: one-cycle pulse coincident with an aborted access's ready
- `address` out 32, `read` out 1, `write` out 1, `byteenable` out 4, `writedata` out 32: bus master outputs, registered
- `readdata` in 32, `waitrequest` in 1: bus master inputs

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset: IDLE, `last_grant`=I, all outputs 0.
- IDLE: grant on any request. If one port requests, grant it. If both request, grant the port not in `last_grant`, so the first tie after reset goes to data. Latch port, address with bits[1:0] forced to 0, and the direction. Drive the bus registers and go to ISSUE. Update `last_grant`.
- ISSUE: hold all bus outputs stable while `waitrequest`=1. When `waitrequest`=0:
  - capture `readdata` into the granted port's rdata (reads only)
  - clear `read`/`write`/`byteenable`
  - go to RESP
- RESP: pulse the granted port's ready. Ignore all requests this cycle. Go to IDLE.
- Reads drive `byteenable`=4'hF. Writes pass `d_byteenable` unchanged, including 4'h0.
- rdata registers hold their value until the next completed read on the same port. Writes do not alter `d_rdata`.
- `stall` is combinational: (`i_req`|`d_read`|`d_write`) & ~(`i_ready`|`d_ready`).
- Requests that drop while in ISSUE do not cancel the bus cycle. The access completes and its ready still pulses.
- Reset in any state returns to IDLE next edge and deasserts `read`/`write` immediately. No ready pulse is issued.

## Timing
- Request high in IDLE at cycle 0: bus asserted in cycle 1.
- With `waitrequest`=0 in cycle 1: ready pulse and valid rdata in cycle 2, IDLE in cycle 3.
- Minimum latency is 2 cycles. Each waitrequest cycle adds 1.
- Throughput: one access per 3 cycles minimum.
- `readdata` is sampled only on the edge where `read`=1 and `waitrequest`=0.

## Configuration
- `MIPS_MEM_ARBITER_TIMEOUT_EN` defined:
  - A counter increments each ISSUE cycle with `waitrequest`=1 and clears on entering ISSUE.
  - On reaching `TIMEOUT_CYCLES`, the access aborts. Bus strobes drop, the granted rdata loads 0 (reads), RESP follows with ready and `err` pulsed together.
- Undefined: no counter. ISSUE waits indefinitely and `err` is tied 0.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the state typedef (IDLE/ISSUE/RESP)
  - the grant typedef (GRANT_I/GRANT_D)
  - the constant for reset `last_grant`
- Optional sub-module `mips_cpu_mem_timeout`: counter with clear/enable/expired. It is instantiated only under the macro.

## Test plan
- Fetch only: `i_req`, `i_addr`=0xBFC00003, `waitrequest`=0, `readdata`=0x12345678. Expect `address`=0xBFC00000 and `read`=1 in cycle 1, then `i_ready`=1 and `i_rdata`=0x12345678 in cycle 2.
- Store: `d_write`, `d_wdata`=0xAABBCCDD, `d_byteenable`=4'b0100, `waitrequest` high 3 cycles. Expect bus outputs stable 4 cycles, `d_ready` in cycle 5, `stall`=1 in cycles 0–4.
- Simultaneous `i_req`+`d_read` held after reset: grants are D, then I, then D. Each ready pulses exactly once per grant, with 3-cycle spacing.
- `d_read` and `d_write` both high: a write is issued and `read`=0.
- Reset asserted in ISSUE with `waitrequest`=1: next cycle `read`=0, IDLE, no ready pulse.
- With the macro and `TIMEOUT_CYCLES`=4, `waitrequest` stuck high: the abort fires after 4 wait cycles, `d_ready`=`err`=1 in the same cycle, `d_rdata`=0.
